// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: fetch/decode/execute/memory/writeback sequencing
// around an external combinational ALU, owning the PC and all memory/RF handshakes.
module cpu_control_fsm #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   ADDRWIDTH = 16,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [ADDRWIDTH-1:0] imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [31:0]          imem_data_i,
  output logic [3:0]           rf_rs1_addr_o,
  output logic [3:0]           rf_rs2_addr_o,
  input  logic [DATAWIDTH-1:0] rf_rs1_data_i,
  input  logic [DATAWIDTH-1:0] rf_rs2_data_i,
  output logic                 rf_we_o,
  output logic [3:0]           rf_waddr_o,
  output logic [DATAWIDTH-1:0] rf_wdata_o,
  output logic [DATAWIDTH-1:0] alu_a_o,
  output logic [DATAWIDTH-1:0] alu_b_o,
  output logic [3:0]           alu_opcode_o,
  input  logic [DATAWIDTH-1:0] alu_out_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDRWIDTH-1:0] dmem_addr_o,
  output logic [DATAWIDTH-1:0] dmem_wdata_o,
  input  logic [DATAWIDTH-1:0] dmem_rdata_i,
  input  logic                 dmem_ack_i,
  output logic                 err_o
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_LW  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8,  OP_LI  = 4'd9,  OP_JMP = 4'd10, OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BGT = 4'd12, OP_BLT = 4'd13;
  localparam logic [ADDRWIDTH-1:0] PC_ONE = 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [DATAWIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;

  logic [3:0]             opcode;
  logic [DATAWIDTH-1:0]   simm, pc_ext;
  logic [ADDRWIDTH-1:0]   pc_inc;
  logic                   taken;
  logic                   imem_req, dmem_req, dmem_we, rf_we;

  assign opcode = ir_q[31:28];
  assign simm   = {{(DATAWIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign pc_ext = {{(DATAWIDTH-ADDRWIDTH){1'b0}}, pc_q};
  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (a_q == b_q);
      OP_BGT:  taken = ($signed(a_q) > $signed(b_q));
      OP_BLT:  taken = ($signed(a_q) < $signed(b_q));
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rs1_data_i;
        b_d     = rf_rs2_data_i;
        state_d = (opcode <= OP_BLT) ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        case (opcode)
          OP_LI:                      begin alu_a_o = '0;     alu_b_o = simm; end
          OP_LW, OP_SW:               begin alu_a_o = a_q;    alu_b_o = simm; end
          OP_JMP, OP_BEQ, OP_BGT,
          OP_BLT:                     begin alu_a_o = pc_ext; alu_b_o = simm; end
          default:                    begin alu_a_o = a_q;    alu_b_o = b_q;  end
        endcase
        // Divide-by-zero result is defined here rather than trusting the ALU.
        res_d = (opcode == OP_DIV && b_q == '0) ? '1 : alu_out_i;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_JMP: begin
            pc_d    = alu_out_i[ADDRWIDTH-1:0];
            state_d = S_FETCH;
          end
          OP_BEQ, OP_BGT, OP_BLT: begin
            pc_d    = taken ? alu_out_i[ADDRWIDTH-1:0] : pc_inc;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req     = 1'b1;
        dmem_we      = (opcode == OP_SW);
        dmem_addr_o  = res_q[ADDRWIDTH-1:0];
        dmem_wdata_o = b_q;
        if (dmem_ack_i) begin
          if (opcode == OP_SW) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata_i;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  // Requests and writes are masked combinationally so reset kills them in the same cycle.
  assign imem_req_o    = imem_req & ~rst_i;
  assign dmem_req_o    = dmem_req & ~rst_i;
  assign dmem_we_o     = dmem_we & ~rst_i;
  assign rf_we_o       = rf_we & ~rst_i;
  assign imem_addr_o   = pc_q;
  assign rf_rs1_addr_o = ir_q[23:20];
  assign rf_rs2_addr_o = (opcode == OP_SW) ? ir_q[27:24] : ir_q[19:16];
  assign rf_waddr_o    = ir_q[27:24];
  assign rf_wdata_o    = res_q;
  assign alu_opcode_o  = opcode;
  assign err_o         = (state_q == S_ERR);

  logic unused_ops;
  assign unused_ops = ^{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR};

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: bench-side RF, ALU and memory responders,
// per-instruction run task recording writes/data accesses, hand-computed expectations.
module tb_cpu_control_fsm;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_LW = 4'd7;
  localparam logic [3:0] OP_SW = 4'd8, OP_LI = 4'd9, OP_JMP = 4'd10, OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BGT = 4'd12, OP_BLT = 4'd13;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [3:0]  rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
  logic        rf_we_o;
  logic [3:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [3:0]  alu_opcode_o;
  logic [31:0] alu_out_i;
  logic        dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic        err_o;

  logic [31:0] rf [16];

  cpu_control_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o), .alu_out_i(alu_out_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .err_o(err_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Environment: register file reads and a reference ALU
  assign rf_rs1_data_i = rf[rf_rs1_addr_o];
  assign rf_rs2_data_i = rf[rf_rs2_addr_o];

  always_comb begin
    case (alu_opcode_o)
      OP_SUB:  alu_out_i = alu_a_o - alu_b_o;
      OP_MUL:  alu_out_i = alu_a_o * alu_b_o;
      OP_DIV:  alu_out_i = (alu_b_o == 0) ? 32'h0 : alu_a_o / alu_b_o;
      OP_AND:  alu_out_i = alu_a_o & alu_b_o;
      OP_OR:   alu_out_i = alu_a_o | alu_b_o;
      OP_XOR:  alu_out_i = alu_a_o ^ alu_b_o;
      default: alu_out_i = alu_a_o + alu_b_o;
    endcase
  end

  // Scoreboard counters and checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Per-instruction observations
  int          cyc, we_cnt, we_cycle, dreq_cnt, err_cycle, busy_in_err;
  logic [3:0]  w_addr;
  logic [31:0] w_data, d_wdata;
  logic [15:0] d_addr;
  logic        d_we, d_stable;

  // Driver: entered at posedge+1 with the DUT in FETCH; returns at the next FETCH
  // (cyc = instruction latency) or after a cycle budget (cyc = -1).
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                           input logic [31:0] rdata);
    int   ic, dc;
    logic fetched, done;
    cyc = 0; we_cnt = 0; we_cycle = 0; dreq_cnt = 0; err_cycle = 0; busy_in_err = 0;
    w_addr = '0; w_data = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_stable = 1'b1;
    ic = 0; dc = 0; fetched = 1'b0; done = 1'b0;
    imem_data_i  = instr;
    dmem_rdata_i = rdata;
    while (!done && cyc < 20) begin
      if (fetched && imem_req_o) begin
        done = 1'b1;
      end else begin
        imem_ack_i = imem_req_o && (ic == iw);
        dmem_ack_i = dmem_req_o && (dc == dw);
        cyc++;
        if (rf_we_o) begin
          we_cnt++; we_cycle = cyc; w_addr = rf_waddr_o; w_data = rf_wdata_o;
        end
        if (dmem_req_o) begin
          if (dreq_cnt == 0) begin
            d_addr = dmem_addr_o; d_we = dmem_we_o; d_wdata = dmem_wdata_o;
          end else if (dmem_addr_o !== d_addr || dmem_we_o !== d_we) begin
            d_stable = 1'b0;
          end
          dreq_cnt++;
        end
        if (err_o && err_cycle == 0) err_cycle = cyc;
        if (err_o && (imem_req_o || dmem_req_o || rf_we_o)) busy_in_err++;
        if (imem_ack_i) fetched = 1'b1;
        if (imem_req_o) ic++;
        if (dmem_req_o) dc++;
        @(posedge clk_i); #1;
      end
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    if (!done) cyc = -1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset behaviour
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_imem_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_dmem_req", 32'(dmem_req_o), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_pc", 32'(imem_addr_o), 32'd0);
    check_eq("rst_alu_a", alu_a_o, 32'd0);
    check_eq("rst_dmem_addr", 32'(dmem_addr_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check_eq("fetch_req_after_rst", 32'(imem_req_o), 32'd1);

    // ADD r3 = r1 + r2 at PC 0
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_instr(mk(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0), 0, 0, 32'h0);
    check_eq("add_cycles", 32'(cyc), 32'd4);
    check_eq("add_we_cnt", 32'(we_cnt), 32'd1);
    check_eq("add_we_cycle", 32'(we_cycle), 32'd4);
    check_eq("add_waddr", 32'(w_addr), 32'd3);
    check_eq("add_wdata", w_data, 32'd12);
    check_eq("add_next_pc", 32'(imem_addr_o), 32'd1);

    // LI r4, 0xFFFE at PC 1
    run_instr(mk(OP_LI, 4'd4, 4'd9, 4'd9, 16'hFFFE), 1, 0, 32'h0);
    check_eq("li_cycles", 32'(cyc), 32'd5);
    check_eq("li_waddr", 32'(w_addr), 32'd4);
    check_eq("li_wdata", w_data, 32'hFFFF_FFFE);
    check_eq("li_next_pc", 32'(imem_addr_o), 32'd2);

    // SW r4 -> [r0 + 8] at PC 2; rs2 field points at a decoy register
    rf[0] = 32'd0; rf[4] = 32'hFFFF_FFFE; rf[5] = 32'h0000_1234;
    run_instr(mk(OP_SW, 4'd4, 4'd0, 4'd5, 16'd8), 0, 0, 32'h0);
    check_eq("sw_cycles", 32'(cyc), 32'd4);
    check_eq("sw_dreq_cycles", 32'(dreq_cnt), 32'd1);
    check_eq("sw_we", 32'(d_we), 32'd1);
    check_eq("sw_addr", 32'(d_addr), 32'd8);
    check_eq("sw_wdata", d_wdata, 32'hFFFF_FFFE);
    check_eq("sw_no_rf_write", 32'(we_cnt), 32'd0);
    check_eq("sw_next_pc", 32'(imem_addr_o), 32'd3);

    // LW r6 = [r1 + 2] at PC 3 with three dmem wait cycles
    rf[1] = 32'd5;
    run_instr(mk(OP_LW, 4'd6, 4'd1, 4'd0, 16'd2), 0, 3, 32'hCAFE_BABE);
    check_eq("lw_cycles", 32'(cyc), 32'd8);
    check_eq("lw_dreq_cycles", 32'(dreq_cnt), 32'd4);
    check_eq("lw_stable", 32'(d_stable), 32'd1);
    check_eq("lw_addr", 32'(d_addr), 32'd7);
    check_eq("lw_we", 32'(d_we), 32'd0);
    check_eq("lw_waddr", 32'(w_addr), 32'd6);
    check_eq("lw_wdata", w_data, 32'hCAFE_BABE);
    check_eq("lw_next_pc", 32'(imem_addr_o), 32'd4);

    // JMP +6 from PC 4 -> 10
    run_instr(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'd6), 0, 0, 32'h0);
    check_eq("jmp_cycles", 32'(cyc), 32'd3);
    check_eq("jmp_target", 32'(imem_addr_o), 32'd10);

    // BLT at PC 10, imm -4: r1 = -1 < r2 = 2 -> taken to 6
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd2;
    run_instr(mk(OP_BLT, 4'd0, 4'd1, 4'd2, 16'hFFFC), 0, 0, 32'h0);
    check_eq("blt_taken_cycles", 32'(cyc), 32'd3);
    check_eq("blt_taken_pc", 32'(imem_addr_o), 32'd6);
    check_eq("blt_no_rf_write", 32'(we_cnt), 32'd0);

    // JMP +4 from PC 6 back to 10, then BLT with r1 = 3 -> not taken to 11
    run_instr(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'd4), 0, 0, 32'h0);
    check_eq("jmp_back_pc", 32'(imem_addr_o), 32'd10);
    rf[1] = 32'd3;
    run_instr(mk(OP_BLT, 4'd0, 4'd1, 4'd2, 16'hFFFC), 0, 0, 32'h0);
    check_eq("blt_not_taken_pc", 32'(imem_addr_o), 32'd11);

    // DIV r7 = r1 / r2 with r2 = 0 at PC 11
    rf[2] = 32'd0;
    run_instr(mk(OP_DIV, 4'd7, 4'd1, 4'd2, 16'h0), 0, 0, 32'h0);
    check_eq("div0_wdata", w_data, 32'hFFFF_FFFF);
    check_eq("div0_next_pc", 32'(imem_addr_o), 32'd12);

    // SUB r8 = 5 - 7 at PC 12
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_instr(mk(OP_SUB, 4'd8, 4'd1, 4'd2, 16'h0), 0, 0, 32'h0);
    check_eq("sub_wdata", w_data, 32'hFFFF_FFFE);

    // BGT at PC 13: signed 3 > -2 -> taken to 15
    rf[1] = 32'd3; rf[2] = 32'hFFFF_FFFE;
    run_instr(mk(OP_BGT, 4'd0, 4'd1, 4'd2, 16'd2), 0, 0, 32'h0);
    check_eq("bgt_signed_pc", 32'(imem_addr_o), 32'd15);

    // JMP -16 from 15 -> 0xFFFF, then JMP +1 wraps to 0
    run_instr(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'hFFF0), 0, 0, 32'h0);
    check_eq("jmp_to_top_pc", 32'(imem_addr_o), 32'h0000_FFFF);
    run_instr(mk(OP_JMP, 4'd0, 4'd0, 4'd0, 16'd1), 0, 0, 32'h0);
    check_eq("jmp_wrap_pc", 32'(imem_addr_o), 32'd0);

    // Undefined opcode: ERR is absorbing
    run_instr(mk(4'hF, 4'd1, 4'd1, 4'd1, 16'h0), 0, 0, 32'h0);
    check_eq("err_no_return", 32'(cyc), 32'hFFFF_FFFF);
    check_eq("err_first_cycle", 32'(err_cycle), 32'd3);
    check_eq("err_no_activity", 32'(busy_in_err), 32'd0);
    check_eq("err_still_set", 32'(err_o), 32'd1);

    // Reset clears ERR; then reset during the MEM phase of a store
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("rst_hold_no_fetch", 32'(imem_req_o), 32'd0);
    rst_i = 1'b0;
    imem_data_i = mk(OP_SW, 4'd4, 4'd0, 4'd5, 16'd8);
    imem_ack_i  = 1'b1;
    @(posedge clk_i); #1;
    imem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("sw_in_mem_req", 32'(dmem_req_o), 32'd1);
    rst_i      = 1'b1;
    dmem_ack_i = 1'b1;
    #1;
    check_eq("rst_masks_store_req", 32'(dmem_req_o), 32'd0);
    check_eq("rst_masks_store_we", 32'(dmem_we_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i      = 1'b0;
    dmem_ack_i = 1'b0;
    #1;
    check_eq("post_rst_err", 32'(err_o), 32'd0);
    check_eq("post_rst_pc", 32'(imem_addr_o), 32'd0);
    check_eq("post_rst_fetch", 32'(imem_req_o), 32'd1);
    check_eq("post_rst_dmem_idle", 32'(dmem_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
